// File: rtl/tree_plru_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tree_plru_pkg
// Description : Shared types and helpers for the tree pseudo-LRU controller.
//               The node vector type is sized for the largest tree (16 ways,
//               15 nodes). Narrower trees use only the low plru_nodes() bits.
// Revision    : 1.0 - initial release
// ============================================================================
package tree_plru_pkg;

  localparam int PLRU_MAX_NODES = 15;
  localparam int PLRU_MAX_WAY_WTH = 4;

  typedef logic [PLRU_MAX_NODES-1:0] plru_state_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_t;

  // Number of tree nodes for a tree with 2**way_wth leaves.
  function automatic int plru_nodes(input int way_wth);
    return (1 << way_wth) - 1;
  endfunction

  // Mark a way most-recently-used: every node on its root-to-leaf path is
  // set to point at the opposite subtree. Node n lives at bit n-1.
  function automatic plru_state_t plru_touch(input plru_state_t bits,
                                             input logic [PLRU_MAX_WAY_WTH-1:0] way,
                                             input int way_wth);
    plru_state_t res;
    int          node;
    logic        dir;
    res  = bits;
    node = 1;
    for (int lvl = 0; lvl < PLRU_MAX_WAY_WTH; lvl++) begin
      if (lvl < way_wth) begin
        dir           = way[way_wth-1-lvl];
        res[node-1]   = ~dir;
        node          = 2 * node + (dir ? 1 : 0);
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tree_plru_victim_sel.sv
`default_nettype none
// ============================================================================
// Module      : plru_victim_sel
// Description : Combinational victim choice for one set. An invalid unlocked
//               way wins outright; otherwise the tree is walked from the root,
//               steering away from any subtree whose ways are all locked.
// Revision    : 1.0 - initial release
// ============================================================================
module plru_victim_sel #(
  parameter int WAY_WTH = 2
) (
  input  logic [(1<<WAY_WTH)-2:0] tree,
  input  logic [(1<<WAY_WTH)-1:0] valid_mask,
  input  logic [(1<<WAY_WTH)-1:0] lock_mask,
  output logic [WAY_WTH-1:0]      way,
  output logic                    err
);

  localparam int WAYS = 1 << WAY_WTH;

  // Priority: all-locked error, then lowest free invalid way, then tree walk.
  always_comb begin : b_select
    int   node;
    int   prefix;
    logic found;
    logic left_free;
    logic right_free;
    logic dir;
    way        = '0;
    err        = 1'b0;
    found      = 1'b0;
    node       = 1;
    prefix     = 0;
    left_free  = 1'b0;
    right_free = 1'b0;
    dir        = 1'b0;
    if (&lock_mask) begin
      err = 1'b1;
    end else begin
      // Descending scan so the lowest matching way is the one kept.
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (!valid_mask[w] && !lock_mask[w]) begin
          way   = WAY_WTH'(w);
          found = 1'b1;
        end
      end
      if (!found) begin
        for (int lvl = 0; lvl < WAY_WTH; lvl++) begin
          left_free  = 1'b0;
          right_free = 1'b0;
          // A way belongs to a child subtree when its top lvl+1 bits match.
          for (int w = 0; w < WAYS; w++) begin
            if (!lock_mask[w]) begin
              if ((w >> (WAY_WTH - 1 - lvl)) == 2 * prefix)
                left_free = 1'b1;
              else if ((w >> (WAY_WTH - 1 - lvl)) == 2 * prefix + 1)
                right_free = 1'b1;
            end
          end
          dir = tree[node-1];
          if (!dir && !left_free)
            dir = 1'b1;
          else if (dir && !right_free)
            dir = 1'b0;
          prefix = 2 * prefix + (dir ? 1 : 0);
          node   = 2 * node + (dir ? 1 : 0);
        end
        way = WAY_WTH'(prefix);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tree_plru.sv
`default_nettype none
// ============================================================================
// Module      : tree_plru
// Description : Tree pseudo-LRU replacement controller for a set-associative
//               cache. Holds one node vector per set in flops, applies MRU
//               touches, answers victim requests one cycle later (with a
//               same-cycle touch bypass) and sweeps all sets clear on flush.
// Revision    : 1.0 - initial release
// ============================================================================
module tree_plru
  import tree_plru_pkg::*;
#(
  parameter int INDEX_WTH = 3,
  parameter int LINE_NUM  = 8,
  parameter int WAY_WTH   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      srst_lru_i,
  output logic                      busy_o,
  input  logic                      update_lru_i,
  input  logic [INDEX_WTH-1:0]      windex_i,
  input  logic [WAY_WTH-1:0]        cur_way_i,
  input  logic                      rd_vld_i,
  input  logic [INDEX_WTH-1:0]      rindex_i,
  input  logic [(1<<WAY_WTH)-1:0]   valid_mask_i,
  input  logic [(1<<WAY_WTH)-1:0]   lock_mask_i,
  output logic                      vtm_vld_o,
  output logic [WAY_WTH-1:0]        vtm_way_o,
  output logic                      vtm_err_o
);

  localparam int                   NODES    = plru_nodes(WAY_WTH);
  localparam logic [INDEX_WTH:0]   LINE_LIM = LINE_NUM[INDEX_WTH:0];
  localparam logic [INDEX_WTH-1:0] CNT_LAST = INDEX_WTH'(LINE_NUM - 1);

  flush_state_t         state;
  flush_state_t         state_nxt;
  logic [INDEX_WTH-1:0] cnt;
  logic [INDEX_WTH-1:0] cnt_nxt;

  logic [NODES-1:0]     tree [LINE_NUM];

  logic                 idle;
  logic                 wr_in_range;
  logic                 rd_in_range;
  logic                 upd_take;
  logic                 rd_take;
  logic [NODES-1:0]     wr_cur;
  logic [NODES-1:0]     wr_new;
  logic [NODES-1:0]     rd_cur;
  logic [NODES-1:0]     rd_tree;
  logic [WAY_WTH-1:0]   sel_way;
  logic                 sel_err;

  assign idle        = (state == ST_IDLE);
  assign busy_o      = (state == ST_FLUSH);
  assign wr_in_range = ({1'b0, windex_i} < LINE_LIM);
  assign rd_in_range = ({1'b0, rindex_i} < LINE_LIM);

  // A flush request in the same cycle beats a touch.
  assign upd_take = update_lru_i && wr_in_range && idle && !srst_lru_i;
  assign rd_take  = rd_vld_i && idle;

  assign wr_cur = wr_in_range ? tree[windex_i] : '0;
  assign wr_new = NODES'(plru_touch(plru_state_t'(wr_cur),
                                    PLRU_MAX_WAY_WTH'(cur_way_i), WAY_WTH));

  // Same-set touch in the same cycle is forwarded into the victim walk.
  assign rd_cur  = rd_in_range ? tree[rindex_i] : '0;
  assign rd_tree = (upd_take && (windex_i == rindex_i)) ? wr_new : rd_cur;

  plru_victim_sel #(
    .WAY_WTH (WAY_WTH)
  ) u_victim_sel (
    .tree       (rd_tree),
    .valid_mask (valid_mask_i),
    .lock_mask  (lock_mask_i),
    .way        (sel_way),
    .err        (sel_err)
  );

  // Flush state and sweep counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Flush sequencing: a new request always restarts the sweep at set 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (srst_lru_i) begin
          state_nxt = ST_FLUSH;
          cnt_nxt   = '0;
        end
      end
      ST_FLUSH: begin
        if (srst_lru_i) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Per-set tree storage: flush clears the swept set, otherwise apply touches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LINE_NUM; i++)
        tree[i] <= '0;
    end else begin
      for (int i = 0; i < LINE_NUM; i++) begin
        if (!idle && (cnt == INDEX_WTH'(i)))
          tree[i] <= '0;
        else if (upd_take && (windex_i == INDEX_WTH'(i)))
          tree[i] <= wr_new;
      end
    end
  end

  // Victim response registers; out-of-range sets answer way 0 without error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vtm_vld_o <= 1'b0;
      vtm_way_o <= '0;
      vtm_err_o <= 1'b0;
    end else begin
      vtm_vld_o <= rd_take;
      if (rd_take) begin
        if (rd_in_range) begin
          vtm_way_o <= sel_way;
          vtm_err_o <= sel_err;
        end else begin
          vtm_way_o <= '0;
          vtm_err_o <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tree_plru.sv
`default_nettype none
// ============================================================================
// Module      : tb_tree_plru
// Description : Self-checking bench for tree_plru (4 ways, 8 sets) with a
//               heap-array reference model and a flush timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tree_plru;

  localparam int IW = 3;
  localparam int LN = 8;
  localparam int WW = 2;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          srst_lru;
  logic          busy;
  logic          update_lru;
  logic [IW-1:0] windex;
  logic [WW-1:0] cur_way;
  logic          rd_vld;
  logic [IW-1:0] rindex;
  logic [W-1:0]  valid_mask;
  logic [W-1:0]  lock_mask;
  logic          vtm_vld;
  logic [WW-1:0] vtm_way;
  logic          vtm_err;

  always #5 clk = ~clk;

  tree_plru #(
    .INDEX_WTH (IW),
    .LINE_NUM  (LN),
    .WAY_WTH   (WW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .srst_lru_i   (srst_lru),
    .busy_o       (busy),
    .update_lru_i (update_lru),
    .windex_i     (windex),
    .cur_way_i    (cur_way),
    .rd_vld_i     (rd_vld),
    .rindex_i     (rindex),
    .valid_mask_i (valid_mask),
    .lock_mask_i  (lock_mask),
    .vtm_vld_o    (vtm_vld),
    .vtm_way_o    (vtm_way),
    .vtm_err_o    (vtm_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: heap-ordered node bits per set (index 1..W-1 used).
  int tree_m [LN][W];
  // Flush timeline: edge count since reset and edge at which the last flush began.
  int ecount;
  int fl_start;
  bit fl_valid;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < LN; s++)
      for (int n = 0; n < W; n++)
        tree_m[s][n] = 0;
    ecount   = 0;
    fl_valid = 1'b0;
    fl_start = 0;
  endfunction

  // Busy after edge e: flush covers edges fl_start .. fl_start+LN-1.
  function automatic bit model_busy(input int e);
    return fl_valid && (e >= fl_start) && (e < fl_start + LN);
  endfunction

  // Climb from the leaf; each parent points to the sibling of the touched child.
  function automatic void model_touch(input int s, input int way);
    int p;
    p = W + way;
    while (p > 1) begin
      tree_m[s][p/2] = (p % 2 == 0) ? 1 : 0;
      p = p / 2;
    end
  endfunction

  function automatic bit subtree_locked(input int c, input logic [W-1:0] lm);
    int lo;
    int hi;
    lo = c;
    hi = c;
    while (lo < W) begin
      lo = 2 * lo;
      hi = 2 * hi + 1;
    end
    for (int p = lo; p <= hi; p++)
      if (!lm[p-W]) return 1'b0;
    return 1'b1;
  endfunction

  // Returns {err, way}.
  function automatic logic [2:0] model_victim(input int s, input logic [W-1:0] vm,
                                              input logic [W-1:0] lm);
    int n;
    int c;
    if (lm == 4'hF) return 3'b100;
    for (int w = 0; w < W; w++)
      if (!vm[w] && !lm[w]) return {1'b0, WW'(w)};
    n = 1;
    while (n < W) begin
      c = 2 * n + tree_m[s][n];
      if (subtree_locked(c, lm)) c = c ^ 1;
      n = c;
    end
    return {1'b0, WW'(n - W)};
  endfunction

  task automatic cycle(input bit up, input int ws, input int wy, input bit rd,
                       input int rs, input logic [W-1:0] vm, input logic [W-1:0] lm,
                       input bit sr);
    bit         exp_vld;
    logic [2:0] exp_r;
    exp_vld    = 1'b0;
    exp_r      = 3'b000;
    update_lru = up;
    windex     = IW'(ws);
    cur_way    = WW'(wy);
    rd_vld     = rd;
    rindex     = IW'(rs);
    valid_mask = vm;
    lock_mask  = lm;
    srst_lru   = sr;
    if (model_busy(ecount)) begin
      for (int s = 0; s < LN; s++)
        if (s == ecount - fl_start)
          for (int n = 0; n < W; n++) tree_m[s][n] = 0;
    end else begin
      if (up && !sr) model_touch(ws, wy);
      exp_vld = rd;
      if (rd) exp_r = model_victim(rs, vm, lm);
    end
    ecount++;
    if (sr) begin
      fl_start = ecount;
      fl_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    check("busy", busy, model_busy(ecount));
    check("vld", vtm_vld, exp_vld);
    if (exp_vld) begin
      check("way", vtm_way, exp_r[1:0]);
      check("err", vtm_err, exp_r[2]);
    end
    update_lru = 1'b0;
    rd_vld     = 1'b0;
    srst_lru   = 1'b0;
  endtask

  task automatic touch(input int s, input int w);
    cycle(1'b1, s, w, 1'b0, 0, 4'hF, 4'h0, 1'b0);
  endtask

  task automatic read(input int s, input logic [W-1:0] vm, input logic [W-1:0] lm);
    cycle(1'b0, 0, 0, 1'b1, s, vm, lm, 1'b0);
  endtask

  task automatic junk();
    cycle(1'b1, $urandom_range(LN-1), $urandom_range(W-1), 1'b1,
          $urandom_range(LN-1), 4'hF, 4'h0, 1'b0);
  endtask

  task automatic touch_all();
    for (int s = 0; s < LN; s++) touch(s, $urandom_range(W-1));
  endtask

  task automatic read_all();
    for (int s = 0; s < LN; s++) read(s, 4'hF, 4'h0);
  endtask

  initial begin
    rst        = 1'b1;
    srst_lru   = 1'b0;
    update_lru = 1'b0;
    windex     = '0;
    cur_way    = '0;
    rd_vld     = 1'b0;
    rindex     = '0;
    valid_mask = 4'hF;
    lock_mask  = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_vld", vtm_vld, 1'b0);
    check("rst_way", vtm_way, 2'd0);
    check("rst_err", vtm_err, 1'b0);
    rst = 1'b0;

    // Basic touch/read ordering on set 5.
    read(5, 4'hF, 4'h0);
    touch(5, 0);
    read(5, 4'hF, 4'h0);
    touch(5, 2);
    read(5, 4'hF, 4'h0);

    // Same-cycle bypass on set 3.
    cycle(1'b1, 3, 0, 1'b1, 3, 4'hF, 4'h0, 1'b0);

    // Lock handling on an untouched set.
    read(0, 4'hF, 4'b0011);
    read(0, 4'hF, 4'b1111);
    read(0, 4'hF, 4'b1011);

    // Invalid-way preference.
    read(5, 4'b1011, 4'h0);
    read(0, 4'b0011, 4'b0100);

    // Full flush with traffic dropped during it.
    touch_all();
    cycle(1'b0, 0, 0, 1'b0, 0, 4'hF, 4'h0, 1'b1);
    repeat (LN) junk();
    read_all();

    // Restarted flush at sweep cycle 4.
    touch_all();
    cycle(1'b0, 0, 0, 1'b0, 0, 4'hF, 4'h0, 1'b1);
    repeat (4) junk();
    cycle(1'b1, 1, 1, 1'b1, 1, 4'hF, 4'h0, 1'b1);
    repeat (LN) junk();
    read_all();

    // Asynchronous reset in the middle of a flush.
    touch_all();
    cycle(1'b0, 0, 0, 1'b0, 0, 4'hF, 4'h0, 1'b1);
    repeat (3) junk();
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_vld", vtm_vld, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    read_all();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(1)), $urandom_range(LN-1), $urandom_range(W-1),
            1'($urandom_range(1)), $urandom_range(LN-1),
            4'($urandom) | 4'($urandom), 4'($urandom) & 4'($urandom),
            ($urandom_range(63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tree_plru.md
# tree_plru

Parameterised tree pseudo-LRU replacement controller for set-associative L2 cache arrays. It supports 2 to 16 ways and any number of sets. It adds a registered victim read port with valid-way preference, way locking, same-cycle update bypass and a sequential set-by-set flush. It sits beside the L2 tag array: the lookup pipeline issues touches on hit or fill, and the refill path requests victims.

## Interface
Parameters:
- INDEX_WTH, 3: set index width
- LINE_NUM, 8: number of sets, 1..2**INDEX_WTH
- WAY_WTH, 2: log2 of ways, 1..4; WAYS = 2**WAY_WTH; tree bits per set NODES = WAYS-1

Ports:
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, asynchronous and active-high
- srst_lru_i  in  1  start a flush sweep of all sets
- busy_o  out  1  flush in progress
- update_lru_i  in  1  touch request
- windex_i  in  INDEX_WTH  touch set
- cur_way_i  in  WAY_WTH  way to mark most-recently-used
- rd_vld_i  in  1  victim request
- rindex_i  in  INDEX_WTH  victim set
- valid_mask_i  in  WAYS  per-way valid bits of set rindex_i
- lock_mask_i  in  WAYS  ways excluded from victimisation
- vtm_vld_o  out  1  victim response valid
- vtm_way_o  out  WAY_WTH  victim way
- vtm_err_o  out  1  all ways locked, so no legal victim

## Operation
- Storage: one NODES-bit vector per set. Bit n-1 holds heap node n; the root is node 1, and the children of n are 2n and 2n+1. A bit value of 0 means the victim lies in the left (lower-way) subtree.
- Touch: for each node on the root-to-leaf path of cur_way_i, set the bit to the inverse of the way bit chosen at that level, so the bit points away from the touched way. Off-path bits are unchanged.
- Touches with windex_i >= LINE_NUM are dropped.
- Victim selection, in priority order:
  1. The lowest-numbered way with valid=0 and lock=0.
  2. Otherwise, walk the tree from the root. At each node, follow the bit unless every way in that subtree is locked; in that case take the sibling.
  3. If all ways are locked, vtm_way_o=0 and vtm_err_o=1.
- Bypass: if update_lru_i and rd_vld_i are both set, target the same set and arrive in the same cycle, selection uses the post-update tree bits.
- rindex_i >= LINE_NUM returns way 0 with vtm_err_o=0.
- FSM states:
  - IDLE: srst_lru_i goes to FLUSH with the counter at 0.
  - FLUSH: each cycle, clear set[cnt] to all zero and increment cnt. After clearing LINE_NUM-1, return to IDLE.
- During FLUSH: busy_o=1, update_lru_i is dropped, rd_vld_i is ignored (no response), and srst_lru_i restarts the counter at 0.
- An srst_lru_i that coincides with an update in IDLE wins; the update is dropped.

## Timing
- Reset state: all tree bits 0, state IDLE, cnt 0, busy_o=0, vtm_vld_o=0, vtm_way_o=0, vtm_err_o=0.
- A touch is visible to a read on the next cycle, or in the same cycle through the bypass.
- Victim latency is 1 cycle. vtm_vld_o, vtm_way_o and vtm_err_o are registered from the rd_vld_i cycle.
- vtm_vld_o is a single-cycle pulse per accepted request. There is no backpressure; a request is accepted on every cycle.
- Flush: srst_lru_i sampled at edge k puts busy_o high from edge k to edge k+LINE_NUM. Set i is cleared at edge k+1+i.
- Reset asserted mid-flush returns the block immediately to its reset state. The flush is not resumed.

## Structure
- hpu_pkg additions:
  - function plru_nodes(way_wth), returning 2**way_wth-1
  - typedef plru_state_t sized for 15 bits, the WAY_WTH=4 maximum, with the top bits masked by parameter
- Sub-module plru_victim_sel: combinational tree walk with valid/lock masks, parameterised by WAY_WTH.
- The top level holds the state array, the touch update, bypass mux, flush FSM and output registers.
- Storage is flops; the array is small enough not to need SRAM.

## Test plan
All scenarios use WAY_WTH=2, LINE_NUM=8, and all-valid, unlocked masks unless stated.
- Reset, then read set 5 -> vtm_way_o=0 and vtm_vld_o on the next cycle. Touch set 5 way 0 -> bits 3'b011, and a read gives way 2. Then touch way 2 -> bits 3'b110, and a read gives way 1.
- Bypass: in the same cycle, touch set 3 way 0 and read set 3 -> the response is way 2, not way 0.
- Locks: after reset, lock_mask_i=4'b0011 -> way 2. With 4'b1111 -> way 0 and vtm_err_o=1. With 4'b1011 -> way 2.
- Invalid preference: valid_mask_i=4'b1011 -> way 2 regardless of tree bits. With valid 4'b0011 and lock 4'b0100 -> way 3.
- Flush: touch all 8 sets, pulse srst_lru_i -> busy_o high for exactly 8 cycles, and touches/reads issued during the flush have no effect or response. Afterwards every set returns way 0. Pulse srst_lru_i again at flush cycle 4 -> busy_o is extended to a full 8 cycles from the restart.
- Async reset at flush cycle 3 -> busy_o=0 immediately, and all sets read way 0.
